// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bus bundle shared by the fetch requester, the data requester,
//               the arbiter and the backing memory port.
//               slave  - the arbiter's view (accepts requests, issues memory)
//               master - the environment's view (requesters + memory model)
// Ports       : if_*  fetch request/response
//               d_*   data (load/store) request/response
//               mem_* unified memory port
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int DATAW = 32,
    parameter int ADDRW = 32
);
    // Fetch path
    logic             if_req;
    logic [ADDRW-1:0] if_addr;
    logic             if_gnt;
    logic             if_rvalid;
    logic [DATAW-1:0] if_rdata;
    // Data path
    logic             d_req;
    logic             d_we;
    logic [1:0]       d_size;
    logic [ADDRW-1:0] d_addr;
    logic [DATAW-1:0] d_wdata;
    logic             d_gnt;
    logic             d_rvalid;
    logic [DATAW-1:0] d_rdata;
    // Memory port
    logic             mem_req;
    logic             mem_we;
    logic [1:0]       mem_size;
    logic [ADDRW-1:0] mem_addr;
    logic [DATAW-1:0] mem_wdata;
    logic             mem_rvalid;
    logic [DATAW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_size, d_addr, d_wdata,
        input  mem_rvalid, mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_size, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_size, d_addr, d_wdata,
        output mem_rvalid, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_size, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between instruction fetch and data
//               load/store. One transaction outstanding at a time; data has
//               priority, but fetch is forced through after STARVE_MAX
//               consecutive data grants that left a fetch waiting.
// Ports       : clk_i          rising-edge clock
//               rst_i          synchronous active-high reset
//               bus            mem_port_arbiter_if.slave request/memory bundle
//               busy_o         a memory access is outstanding
//               err_spurious_o sticky: memory response with nothing pending
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int DATAW      = 32,
    parameter int ADDRW      = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    mem_port_arbiter_if.slave     bus,
    output logic                  busy_o,
    output logic                  err_spurious_o
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [1:0] SIZE_WORD  = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       starve_q, starve_d;
    logic             store_q;          // outstanding data access is a store
    logic             if_rvalid_q, d_rvalid_q;
    logic [DATAW-1:0] if_rdata_q, d_rdata_q;
    logic             err_q;

    logic             grant_if, grant_d;
    logic             mem_req_c, mem_we_c;
    logic [1:0]       mem_size_c;
    logic [ADDRW-1:0] mem_addr_c;
    logic [DATAW-1:0] mem_wdata_c;

    // ------------------------------------------------------------------
    // Arbitration, memory issue and next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        grant_if    = 1'b0;
        grant_d     = 1'b0;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        mem_size_c  = 2'b00;
        mem_addr_c  = '0;
        mem_wdata_c = '0;

        case (state_q)
            IDLE: begin
                // Data wins a tie unless fetch has already waited out its quota
                if (bus.if_req && (!bus.d_req || starve_q == STARVE_LIM)) begin
                    grant_if = 1'b1;
                end else if (bus.d_req) begin
                    grant_d = 1'b1;
                end

                if (grant_if) begin
                    state_d    = WAIT_I;
                    mem_req_c  = 1'b1;
                    mem_size_c = SIZE_WORD;
                    mem_addr_c = bus.if_addr;
                end else if (grant_d) begin
                    state_d     = WAIT_D;
                    mem_req_c   = 1'b1;
                    mem_we_c    = bus.d_we;
                    mem_size_c  = bus.d_size;
                    mem_addr_c  = bus.d_addr;
                    mem_wdata_c = bus.d_wdata;
                end
            end
            WAIT_I, WAIT_D: begin
                if (bus.mem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Starvation counter: counts data grants that overtook a waiting fetch
    // ------------------------------------------------------------------
    always_comb begin
        starve_d = starve_q;
        if (grant_if) begin
            starve_d = '0;
        end else if (state_q == IDLE && !bus.if_req) begin
            starve_d = '0;
        end else if (grant_d && bus.if_req && starve_q < STARVE_LIM) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // State and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            store_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            if_rvalid_q <= (state_q == WAIT_I) && bus.mem_rvalid;
            d_rvalid_q  <= (state_q == WAIT_D) && bus.mem_rvalid;

            if (grant_d) begin
                store_q <= bus.d_we;
            end
            if (state_q == WAIT_I && bus.mem_rvalid) begin
                if_rdata_q <= bus.mem_rdata;
            end
            // Stores complete with zero data so the core never sees stale bus data
            if (state_q == WAIT_D && bus.mem_rvalid) begin
                d_rdata_q <= store_q ? '0 : bus.mem_rdata;
            end
            // A response with nothing outstanding (incl. one abandoned by reset)
            if (state_q == IDLE && bus.mem_rvalid) begin
                err_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.if_gnt    = grant_if;
    assign bus.d_gnt     = grant_d;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_req   = mem_req_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_size  = mem_size_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;
    assign busy_o         = (state_q != IDLE);
    assign err_spurious_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. Single-requester
//               transactions come from a vector table; tie-break, starvation
//               and reset/spurious-response cases are hand-written sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, err_spurious;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.DATAW(32), .ADDRW(32)) bus ();

    mem_port_arbiter #(.DATAW(32), .ADDRW(32), .STARVE_MAX(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .bus            (bus),
        .busy_o         (busy),
        .err_spurious_o (err_spurious)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        is_fetch;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;        // cycles from grant to mem_rvalid
        logic [31:0] mrdata;     // data the memory returns
        logic        exp_we;
        logic [1:0]  exp_size;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;  // data the requester must see
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = '0;
        bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},    {30'd0, bus.if_gnt, bus.d_gnt}, 32'd0);
        chk({tag, "_rvalid"}, {30'd0, bus.if_rvalid, bus.d_rvalid}, 32'd0);
        chk({tag, "_ifrd"},   bus.if_rdata, 32'd0);
        chk({tag, "_drd"},    bus.d_rdata, 32'd0);
        chk({tag, "_memctl"}, {27'd0, bus.mem_req, bus.mem_we, bus.mem_size, busy}, 32'd0);
        chk({tag, "_memaddr"}, bus.mem_addr, 32'd0);
        chk({tag, "_memwd"},  bus.mem_wdata, 32'd0);
        chk({tag, "_err"},    {31'd0, err_spurious}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string p;
        p = $sformatf("v%0d", idx);
        // Cycle 0: request and same-cycle grant
        if (v.is_fetch) begin
            bus.if_req = 1'b1; bus.if_addr = v.addr;
        end else begin
            bus.d_req = 1'b1; bus.d_we = v.we; bus.d_size = v.size;
            bus.d_addr = v.addr; bus.d_wdata = v.wdata;
        end
        @(negedge clk);
        chk({p, "_gnt"}, {30'd0, bus.if_gnt, bus.d_gnt}, v.is_fetch ? 32'd2 : 32'd1);
        chk({p, "_memreq"}, {31'd0, bus.mem_req}, 32'd1);
        chk({p, "_memwe"}, {31'd0, bus.mem_we}, {31'd0, v.exp_we});
        chk({p, "_memsize"}, {30'd0, bus.mem_size}, {30'd0, v.exp_size});
        chk({p, "_memaddr"}, bus.mem_addr, v.addr);
        chk({p, "_memwdata"}, bus.mem_wdata, v.exp_wdata);
        chk({p, "_busy0"}, {31'd0, busy}, 32'd0);
        next_cycle();
        clear_inputs();
        // Cycles 1..k: outstanding, memory answers in cycle k
        for (int c = 1; c <= v.lat; c++) begin
            if (c == v.lat) begin
                bus.mem_rvalid = 1'b1; bus.mem_rdata = v.mrdata;
            end
            @(negedge clk);
            chk({p, "_busy"}, {31'd0, busy}, 32'd1);
            chk({p, "_wait_quiet"}, {29'd0, bus.mem_req, bus.if_rvalid, bus.d_rvalid}, 32'd0);
            next_cycle();
        end
        clear_inputs();
        // Cycle k+1: response strobe
        @(negedge clk);
        chk({p, "_rvalid"}, {30'd0, bus.if_rvalid, bus.d_rvalid}, v.is_fetch ? 32'd2 : 32'd1);
        chk({p, "_rdata"}, v.is_fetch ? bus.if_rdata : bus.d_rdata, v.exp_rdata);
        chk({p, "_idle_mem"}, {bus.mem_addr[27:0], bus.mem_req, bus.mem_we, bus.mem_size} | bus.mem_wdata, 32'd0);
        chk({p, "_busy_end"}, {31'd0, busy}, 32'd0);
        next_cycle();
        // Strobe is one cycle; data holds
        @(negedge clk);
        chk({p, "_strobe_off"}, {30'd0, bus.if_rvalid, bus.d_rvalid}, 32'd0);
        chk({p, "_rdata_hold"}, v.is_fetch ? bus.if_rdata : bus.d_rdata, v.exp_rdata);
        next_cycle();
    endtask

    int g;
    logic pend;
    logic [31:0] exp_pair;

    initial begin
        //              fetch we size   addr          wdata         lat mrdata        exp_we size  exp_wdata     exp_rdata
        vecs[0] = '{1'b1, 1'b0, 2'b00, 32'h0100_0000, 32'h0,        2, 32'h0000_0013, 1'b0, 2'b10, 32'h0,        32'h0000_0013};
        vecs[1] = '{1'b0, 1'b1, 2'b00, 32'h0100_0100, 32'h0000_00AB, 1, 32'h0,        1'b1, 2'b00, 32'h0000_00AB, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 2'b10, 32'h0100_0204, 32'h0,        3, 32'hDEAD_BEEF, 1'b0, 2'b10, 32'h0,        32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 1'b0, 2'b01, 32'h0100_0302, 32'h0,        1, 32'h0000_8001, 1'b0, 2'b01, 32'h0,        32'h0000_8001};
        vecs[4] = '{1'b1, 1'b0, 2'b00, 32'h0100_0004, 32'h0,        1, 32'h1234_5678, 1'b0, 2'b10, 32'h0,        32'h1234_5678};
        vecs[5] = '{1'b0, 1'b1, 2'b10, 32'h0100_0400, 32'hF00D_CAFE, 2, 32'h5555_5555, 1'b1, 2'b10, 32'hF00D_CAFE, 32'h0};

        clear_inputs();
        rst = 1'b1;
        // Reset state: everything zero during and just after reset
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_all_zero("rst");
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("post_rst");
        next_cycle();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
        end

        // Simultaneous requests: data first, fetch right after d_rvalid
        bus.if_req = 1'b1; bus.if_addr = 32'h0100_0040;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'b10; bus.d_addr = 32'h0100_0200;
        @(negedge clk);
        chk("sim_gnt0", {30'd0, bus.if_gnt, bus.d_gnt}, 32'd1);
        chk("sim_addr0", bus.mem_addr, 32'h0100_0200);
        next_cycle();
        bus.d_req = 1'b0; bus.d_addr = '0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE_0001;
        @(negedge clk);
        chk("sim_gnt1", {30'd0, bus.if_gnt, bus.d_gnt}, 32'd0);
        chk("sim_busy1", {31'd0, busy}, 32'd1);
        next_cycle();
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        @(negedge clk);
        chk("sim_drvalid", {31'd0, bus.d_rvalid}, 32'd1);
        chk("sim_drdata", bus.d_rdata, 32'hCAFE_0001);
        chk("sim_ifgnt", {30'd0, bus.if_gnt, bus.d_gnt}, 32'd2);
        chk("sim_ifaddr", bus.mem_addr, 32'h0100_0040);
        chk("sim_ifsize", {30'd0, bus.mem_size}, 32'd2);
        next_cycle();
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_0093;
        @(negedge clk);
        chk("sim_busy3", {31'd0, busy}, 32'd1);
        next_cycle();
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        @(negedge clk);
        chk("sim_ifrvalid", {30'd0, bus.if_rvalid, bus.d_rvalid}, 32'd2);
        chk("sim_ifrdata", bus.if_rdata, 32'h0000_0093);
        chk("sim_drdata_hold", bus.d_rdata, 32'hCAFE_0001);
        next_cycle();
        next_cycle();

        // Starvation: both held, memory latency 1; expect D D D D F repeating
        bus.if_req = 1'b1; bus.if_addr = 32'h0100_0080;
        bus.d_req = 1'b1; bus.d_addr = 32'h0100_0500;
        g = 0;
        pend = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            bus.mem_rvalid = pend;
            @(negedge clk);
            if (bus.if_gnt || bus.d_gnt) begin
                exp_pair = (g % 5 == 4) ? 32'd2 : 32'd1;
                chk($sformatf("starve_gnt%0d", g), {30'd0, bus.if_gnt, bus.d_gnt}, exp_pair);
                g++;
            end
            pend = bus.mem_req;
            next_cycle();
        end
        chk("starve_grants", g, 32'd10);
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        bus.mem_rvalid = pend;
        next_cycle();
        clear_inputs();
        next_cycle();
        @(negedge clk);
        chk("starve_idle", {30'd0, busy, err_spurious}, 32'd0);
        next_cycle();

        // Reset in WAIT_D, then a late memory response
        bus.d_req = 1'b1; bus.d_addr = 32'h0100_0600;
        @(negedge clk);
        chk("rd_gnt", {30'd0, bus.if_gnt, bus.d_gnt}, 32'd1);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        chk("rd_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("rd_busy_rst", {31'd0, busy}, 32'd0);
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rd_quiet", {29'd0, busy, bus.d_rvalid, err_spurious}, 32'd0);
            next_cycle();
        end
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h7777_7777;
        @(negedge clk);
        chk("rd_err_pre", {31'd0, err_spurious}, 32'd0);
        next_cycle();
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rd_err_sticky", {29'd0, err_spurious, busy, bus.d_rvalid}, 32'd4);
            chk("rd_rdata", bus.d_rdata, 32'd0);
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
